// File: rtl/fwd_pkg.sv
// Shared definitions for the ID/EX operand stage: forwarding select codes,
// hazard FSM states and stall counter width.
package fwd_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Wide enough for the longest load-use stall (7 bubbles).
  localparam int CNT_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_select.sv
// One operand's forwarding decision: index compare against EX/MEM and MEM/WB,
// priority select and the DATA_W 3:1 operand mux.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_op,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] operand
);

  logic exmem_hit;
  logic memwb_hit;

  // Register 0 is hard-zero, so a write to it never produces a forward.
  assign exmem_hit = ex_valid && exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs);
  assign memwb_hit = ex_valid && memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    sel     = FWD_REG;
    operand = ex_op;
    if (exmem_hit) begin
      sel     = FWD_EXMEM;
      operand = exmem_result;
    end else if (memwb_hit) begin
      sel     = FWD_MEMWB;
      operand = memwb_result;
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand stage: registers source operands, forwards from EX/MEM and
// MEM/WB, and stalls on load-use hazards. FWD_STATS_EN adds event counters.
module fwd_operand_stage
  import fwd_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_AW         = 5,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC*DATA_W-1:0]   id_rdata,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic                        id_reg_write,
  input  logic                        id_mem_read,
  input  logic                        flush,
  input  logic [REG_AW-1:0]           exmem_rd,
  input  logic                        exmem_reg_write,
  input  logic [DATA_W-1:0]           exmem_result,
  input  logic [REG_AW-1:0]           memwb_rd,
  input  logic                        memwb_reg_write,
  input  logic [DATA_W-1:0]           memwb_result,
  output logic                        stall,
  output logic                        ex_valid,
  output logic [REG_AW-1:0]           ex_rd,
  output logic                        ex_reg_write,
  output logic                        ex_mem_read,
  output logic [NUM_SRC*2-1:0]        ex_fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]   alu_in,
  output logic [31:0]                 stat_fwd_cnt,
  output logic [31:0]                 stat_stall_cnt
);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_SRC*REG_AW-1:0]   ex_rs_q;
  logic [NUM_SRC*DATA_W-1:0]   ex_op_q;
  logic [NUM_SRC*DATA_W-1:0]   id_op;
  logic                        rs_match;
  logic                        hazard;
  logic                        bubble;

  always_comb begin
    rs_match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_rs[k*REG_AW +: REG_AW] == ex_rd) rs_match = 1'b1;
    end
  end

  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && rs_match;

  // A result retiring this cycle is not yet visible in the register file read.
  always_comb begin
    id_op = id_rdata;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs[k*REG_AW +: REG_AW]))
        id_op[k*DATA_W +: DATA_W] = memwb_result;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            stall = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = STALL;
              cnt_d   = CNT_W'(LOAD_STALL_CYC - 1);
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bubble = flush || stall || !id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_rs_q      <= '0;
      ex_op_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_rs_q <= id_rs;
      ex_op_q <= id_op;
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end else begin
        ex_valid     <= 1'b1;
        ex_rd        <= id_rd;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
      end
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_select #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_sel (
      .ex_valid        (ex_valid),
      .ex_rs           (ex_rs_q[k*REG_AW +: REG_AW]),
      .ex_op           (ex_op_q[k*DATA_W +: DATA_W]),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_result    (exmem_result),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_result    (memwb_result),
      .sel             (ex_fwd_sel[k*2 +: 2]),
      .operand         (alu_in[k*DATA_W +: DATA_W])
    );
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if ((|ex_fwd_sel) && (stat_fwd_cnt != '1)) stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      if (stall && (stat_stall_cnt != '1))       stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`else
  assign stat_fwd_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: doc/fwd_operand_stage.md
Name: fwd_operand_stage

Overview:
- Parametrised ID/EX operand stage for the pipelined CPU.
- Registers NUM_SRC source operands from ID and resolves RAW hazards against EX/MEM and MEM/WB by forwarding.
- Detects load-use hazards and stalls the front end, inserting bubbles.
- Drives ALU operands directly. Replaces the per-operand 3:1 forwarding mux with a single unit covering all operands, hazard control and ID/EX state.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register index width; index 0 is hard-zero and never forwarded.
- NUM_SRC, 2, source operands per instruction (1..3).
- LOAD_STALL_CYC, 1, bubbles per load-use hazard (1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_AW  source indices, operand k at [k*REG_AW +: REG_AW].
- id_rdata  in  NUM_SRC*DATA_W  register-file read data, same packing.
- id_rd  in  REG_AW  destination index.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  squash ID/EX (branch redirect).
- exmem_rd  in  REG_AW  destination index in EX/MEM.
- exmem_reg_write  in  1  EX/MEM will write its destination.
- exmem_result  in  DATA_W  EX/MEM result.
- memwb_rd  in  REG_AW  destination index in MEM/WB.
- memwb_reg_write  in  1  MEM/WB will write its destination.
- memwb_result  in  DATA_W  MEM/WB result.
- stall  out  1  hold PC and IF/ID.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_rd  out  REG_AW  registered destination.
- ex_reg_write  out  1  registered; forced 0 on bubble.
- ex_mem_read  out  1  registered; forced 0 on bubble.
- ex_fwd_sel  out  NUM_SRC*2  per-operand select.
- alu_in  out  NUM_SRC*DATA_W  resolved ALU operands.

Behaviour:
- Reset (async, rst_n=0): ex_valid, ex_reg_write, ex_mem_read = 0; ex_rd and operand registers = 0; FSM = RUN; counter = 0; stall = 0.
- Select encoding per operand k, evaluated on registered ex_rs[k]:
  - 2'b01 EX/MEM if exmem_reg_write, exmem_rd != 0 and exmem_rd == ex_rs[k].
  - Else 2'b10 MEM/WB on the same test with memwb_*.
  - Else 2'b00 registered operand.
  - EX/MEM beats MEM/WB on a double match.
  - Select is 2'b00 whenever ex_valid = 0.
- alu_in[k] is combinational from the select; zero-cycle latency from the EX/MEM and MEM/WB inputs.
- ID capture bypass: if memwb_reg_write, memwb_rd != 0 and memwb_rd == id_rs[k], the operand register captures memwb_result instead of id_rdata. This covers register-file read-before-write.
- Load-use hazard (combinational) requires all of:
  - id_valid, ex_valid, ex_mem_read, ex_rd != 0;
  - some k with id_rs[k] == ex_rd.
- FSM:
  - RUN: on hazard, stall = 1 and ID/EX loads a bubble (ex_valid = 0, control = 0). If LOAD_STALL_CYC > 1, go to STALL with counter = LOAD_STALL_CYC-1.
  - STALL: stall = 1, bubbles continue, counter decrements. When counter == 1, return to RUN next edge.
  - Otherwise ID/EX loads ID fields when stall = 0.
- flush has priority over everything:
  - ID/EX loads a bubble.
  - FSM goes to RUN; counter cleared.
  - stall is forced 0 in that cycle.
- id_valid = 0: ID/EX loads a bubble; no hazard is possible.
- Reset asserted mid-STALL: immediate return to RUN, stall = 0.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined:
  - Ports stat_fwd_cnt (32) and stat_stall_cnt (32) are outputs.
  - stat_fwd_cnt increments by 1 per cycle in which any ex_fwd_sel is nonzero.
  - stat_stall_cnt increments by 1 per cycle with stall = 1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: both ports are present and driven to constant 0; no counter logic.

Decomposition:
- Package fwd_pkg holds:
  - FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - FSM state encoding: RUN, STALL.
- Sub-module fwd_select: one operand's index compare, priority select and DATA_W 3:1 mux, instantiated NUM_SRC times.
- Hazard FSM, counter and ID/EX registers stay in the top module.

Test Plan:
- EX/MEM forward: ID/EX holds rs0=3; EX/MEM rd=3, write=1, result=32'h0000_00AA -> ex_fwd_sel[1:0]=01, alu_in[0]=32'hAA.
- Double match: rs1=7; EX/MEM rd=7 result 32'h11; MEM/WB rd=7 result 32'h22 -> select 01, alu_in[1]=32'h11. Repeat with rs=0 -> select 00, operand unchanged.
- Load-use, LOAD_STALL_CYC=1: ex_mem_read=1, ex_rd=4; ID rs0=4 -> stall=1 for exactly 1 cycle, ex_valid=0 next cycle, dependent instruction enters ID/EX on the following edge.
- LOAD_STALL_CYC=3, same hazard -> stall high 3 consecutive cycles, 3 bubbles. Then assert flush in stall cycle 2 -> stall=0 in that cycle, FSM in RUN, ID/EX bubble.
- ID capture bypass: MEM/WB rd=5 result 32'hDEAD_BEEF, ID rs0=5, id_rdata=0 -> registered operand reads 32'hDEADBEEF next cycle with select 00.
- Reset mid-STALL: rst_n low during STALL -> stall=0, ex_valid=0 immediately. With FWD_STATS_EN: stat_stall_cnt equals the number of stall cycles observed, and is 0 after reset.
